// File: rtl/fma_pkg.sv
// fma_pkg: shared fma constants (default width, {a,b,c} packing offsets) and sequencer state enum
package fma_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int C_MSB = WIDTH_DEF - 1;
  localparam int B_MSB = 2 * WIDTH_DEF - 1;
  localparam int A_MSB = 3 * WIDTH_DEF - 1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RESULT} state_t;
endpackage

// File: rtl/fma_dot_sequencer_if.sv
// fma_dot_sequencer_if: cmd/ab/res handshakes and fma controls; slave = sequencer side, master = environment side
interface fma_dot_sequencer_if #(
  parameter int WIDTH = fma_pkg::WIDTH_DEF,
  parameter int LEN_W = 8
);
  logic               cmd_valid_in;
  logic               cmd_ready_out;
  logic [LEN_W-1:0]   cmd_len_in;
  logic [WIDTH-1:0]   cmd_c_in;
  logic               ab_valid_in;
  logic               ab_ready_out;
  logic [2*WIDTH-1:0] ab_in;
  logic [3*WIDTH-1:0] fma_abc_out;
  logic               fma_valid_out;
  logic               fma_c_valid_out;
  logic               fma_output_can_be_valid_out;
  logic [WIDTH-1:0]   fma_out_in;
  logic               fma_valid_in;
  logic               res_valid_out;
  logic               res_ready_in;
  logic [WIDTH-1:0]   res_data_out;
  modport slave (
    input  cmd_valid_in, cmd_len_in, cmd_c_in, ab_valid_in, ab_in, fma_out_in, fma_valid_in, res_ready_in,
    output cmd_ready_out, ab_ready_out, fma_abc_out, fma_valid_out, fma_c_valid_out,
           fma_output_can_be_valid_out, res_valid_out, res_data_out
  );
  modport master (
    output cmd_valid_in, cmd_len_in, cmd_c_in, ab_valid_in, ab_in, fma_out_in, fma_valid_in, res_ready_in,
    input  cmd_ready_out, ab_ready_out, fma_abc_out, fma_valid_out, fma_c_valid_out,
           fma_output_can_be_valid_out, res_valid_out, res_data_out
  );
endinterface

// File: rtl/fma_dot_sequencer.sv
// fma_dot_sequencer: takes {N,c}, streams N {a,b} pairs as registered fma issues, returns the accumulated result on res (ports: clk_in, rst_in, bus.slave)
module fma_dot_sequencer import fma_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = 8
) (
  input logic                clk_in,
  input logic                rst_in,
  fma_dot_sequencer_if.slave bus
);
  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic [WIDTH-1:0]   c_q, c_d, res_q, res_d;
  logic [3*WIDTH-1:0] abc_q, abc_d;
  logic               valid_q, valid_d, c_valid_q, c_valid_d, ocbv_q, ocbv_d;
  logic               last, empty;
  always_comb begin
    last = rem_q == LEN_W'(1);
    empty = bus.cmd_len_in == '0;
    state_d = state_q;
    rem_d = rem_q;
    first_d = first_q;
    c_d = c_q;
    res_d = res_q;
    abc_d = abc_q;
    valid_d = 1'b0;
    c_valid_d = 1'b0;
    ocbv_d = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid_in) begin
        c_d = bus.cmd_c_in;
        res_d = empty ? bus.cmd_c_in : res_q;
        rem_d = bus.cmd_len_in;
        first_d = !empty;
        state_d = empty ? RESULT : STREAM;
      end
      STREAM: if (bus.ab_valid_in) begin
        valid_d = 1'b1;
        abc_d = {bus.ab_in, c_q};
        c_valid_d = first_q;
        ocbv_d = last;
        first_d = 1'b0;
        rem_d = rem_q - LEN_W'(1);
        state_d = last ? DRAIN : STREAM;
      end
      DRAIN: if (bus.fma_valid_in) begin
        res_d = bus.fma_out_in;
        state_d = RESULT;
      end
      RESULT: state_d = bus.res_ready_in ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      rem_q <= '0;
      first_q <= 1'b0;
      c_q <= '0;
      res_q <= '0;
      abc_q <= '0;
      valid_q <= 1'b0;
      c_valid_q <= 1'b0;
      ocbv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      first_q <= first_d;
      c_q <= c_d;
      res_q <= res_d;
      abc_q <= abc_d;
      valid_q <= valid_d;
      c_valid_q <= c_valid_d;
      ocbv_q <= ocbv_d;
    end
  end
  assign bus.cmd_ready_out = state_q == IDLE;
  assign bus.ab_ready_out = state_q == STREAM;
  assign bus.res_valid_out = state_q == RESULT;
  assign bus.res_data_out = res_q;
  assign bus.fma_abc_out = abc_q;
  assign bus.fma_valid_out = valid_q;
  assign bus.fma_c_valid_out = c_valid_q;
  assign bus.fma_output_can_be_valid_out = ocbv_q;
endmodule

// File: tb/tb_fma_dot_sequencer.sv
// tb_fma_dot_sequencer: sequencer plus a behavioural fma (FIXED_POINT=10), directed and random dot products against a sum model
module tb_fma_dot_sequencer;
  import fma_pkg::*;
  typedef struct packed {logic [47:0] abc; logic cv; logic ov; int cyc;} iss_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spur = 1'b0;
  logic [15:0] fma_acc, fma_out;
  logic fma_v;
  int n_cmp = 0, n_err = 0, cyc = 0;
  iss_t iss[$];
  logic [15:0] pa[$], pb[$];
  always #5 clk = ~clk;
  fma_dot_sequencer_if #(.WIDTH(16), .LEN_W(8)) bus ();
  fma_dot_sequencer #(.WIDTH(16), .LEN_W(8)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  function automatic logic [15:0] fma_mac(logic [47:0] abc, logic cv, logic [15:0] acc);
    logic [31:0] p;
    p = 32'(abc[A_MSB -: 16]) * 32'(abc[B_MSB -: 16]);
    return (cv ? abc[C_MSB -: 16] : acc) + p[25:10];
  endfunction
  assign bus.fma_valid_in = fma_v | spur;
  assign bus.fma_out_in = spur ? 16'hDEAD : fma_out;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      fma_acc <= '0;
      fma_out <= '0;
      fma_v <= 1'b0;
    end else begin
      fma_v <= bus.fma_valid_out && bus.fma_output_can_be_valid_out;
      if (bus.fma_valid_out) begin
        fma_acc <= fma_mac(bus.fma_abc_out, bus.fma_c_valid_out, fma_acc);
        fma_out <= fma_mac(bus.fma_abc_out, bus.fma_c_valid_out, fma_acc);
      end
    end
  end
  always @(negedge clk)
    if (!rst && bus.fma_valid_out)
      iss.push_back('{bus.fma_abc_out, bus.fma_c_valid_out, bus.fma_output_can_be_valid_out, cyc});
  function automatic void chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset(string tag);
    chk({tag, "_ready"}, {bus.cmd_ready_out, bus.ab_ready_out, bus.res_valid_out}, 3'b100);
    chk({tag, "_res"}, bus.res_data_out, 0);
    chk({tag, "_issue"}, {bus.fma_valid_out, bus.fma_c_valid_out, bus.fma_output_can_be_valid_out}, 0);
    chk({tag, "_abc"}, bus.fma_abc_out, 0);
  endtask
  task automatic send_cmd(input int n, input logic [15:0] c, output int e, output int w);
    w = 0;
    bus.cmd_valid_in = 1'b1;
    bus.cmd_len_in = 8'(n);
    bus.cmd_c_in = c;
    while (!bus.cmd_ready_out && w < 50) begin
      tick();
      w++;
    end
    chk("cmd_wait_bound", 64'(w < 50), 1);
    tick();
    e = cyc;
    bus.cmd_valid_in = 1'b0;
  endtask
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input int gap, output int e);
    int w = 0;
    bus.ab_valid_in = 1'b0;
    repeat (gap) tick();
    bus.ab_valid_in = 1'b1;
    bus.ab_in = {a, b};
    while (!bus.ab_ready_out && w < 50) begin
      tick();
      w++;
    end
    chk("ab_wait_bound", 64'(w < 50), 1);
    tick();
    e = cyc;
    bus.ab_valid_in = 1'b0;
  endtask
  task automatic run_dot(input int n, input logic [15:0] c, input int gap, input int rdly, output int wait_cmd);
    logic [15:0] exp;
    int ec, e, w, want;
    int acc_e[$];
    exp = c;
    iss.delete();
    send_cmd(n, c, ec, wait_cmd);
    for (int i = 0; i < n; i++) begin
      exp = exp + 16'((longint'(pa[i]) * longint'(pb[i])) >> 10);
      send_pair(pa[i], pb[i], i == 0 ? 0 : gap, e);
      acc_e.push_back(e);
    end
    w = 0;
    while (!bus.res_valid_out && w < 50) begin
      tick();
      w++;
    end
    want = ec;
    if (n > 0) want = acc_e[n-1] + 2;
    chk("res_latency", 64'(cyc), 64'(want));
    chk("res_data", bus.res_data_out, exp);
    repeat (rdly) begin
      tick();
      chk("res_hold_valid", bus.res_valid_out, 1);
      chk("res_hold_data", bus.res_data_out, exp);
      chk("cmd_ready_busy", bus.cmd_ready_out, 0);
    end
    bus.res_ready_in = 1'b1;
    tick();
    bus.res_ready_in = 1'b0;
    chk("idle_after_res", {bus.cmd_ready_out, bus.res_valid_out}, 2'b10);
    chk("issue_count", 64'(iss.size()), 64'(n));
    for (int i = 0; i < n && i < iss.size(); i++) begin
      chk("issue_abc", iss[i].abc, {pa[i], pb[i], c});
      chk("issue_c_valid", iss[i].cv, i == 0);
      chk("issue_ocbv", iss[i].ov, i == n - 1);
      chk("issue_cycle", 64'(iss[i].cyc), 64'(acc_e[i]));
    end
  endtask
  initial begin
    int e, w, n;
    logic [15:0] held;
    bus.cmd_valid_in = 1'b0;
    bus.cmd_len_in = '0;
    bus.cmd_c_in = '0;
    bus.ab_valid_in = 1'b0;
    bus.ab_in = '0;
    bus.res_ready_in = 1'b0;
    repeat (2) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    pa = '{16'h0400, 16'h0200, 16'h0800};
    pb = '{16'h0800, 16'h0400, 16'h0800};
    run_dot(3, 16'h0400, 0, 0, w);
    chk("t1_value", bus.res_data_out, 16'h1E00);
    run_dot(0, 16'h0C00, 0, 0, w);
    run_dot(3, 16'h0400, 2, 1, w);
    chk("t3_value", bus.res_data_out, 16'h1E00);
    pa = '{16'h0400};
    pb = '{16'h0400};
    run_dot(1, 16'h0000, 0, 5, w);
    pa = '{16'h0400, 16'h0800, 16'h0200, 16'h0400};
    pb = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    send_cmd(4, 16'h0400, e, w);
    chk("cmd_next_cycle", 64'(w), 0);
    send_pair(pa[0], pb[0], 0, e);
    send_pair(pa[1], pb[1], 0, e);
    rst = 1'b1;
    tick();
    check_reset("midreset");
    rst = 1'b0;
    pa = '{16'h0400};
    pb = '{16'h0400};
    run_dot(1, 16'h0000, 0, 0, w);
    chk("t5_value", bus.res_data_out, 16'h0400);
    run_dot(1, 16'h0000, 0, 0, w);
    held = bus.res_data_out;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk("spurious_res", bus.res_data_out, held);
    chk("spurious_state", {bus.cmd_ready_out, bus.res_valid_out}, 2'b10);
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, 6);
      pa.delete();
      pb.delete();
      for (int i = 0; i < n; i++) begin
        pa.push_back(16'($urandom));
        pb.push_back(16'($urandom));
      end
      run_dot(n, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), w);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
